// File: rtl/operand_stage_pkg.sv
// Shared constants for the operand-fetch stage: datapath sizing and ALU control codes.
package operand_stage_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned NumRegs   = 32;
    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned ImmWidth  = 16;

    typedef enum logic [2:0] {
        CtrlAnd = 3'b000,
        CtrlOr  = 3'b001,
        CtrlAdd = 3'b010,
        CtrlSub = 3'b011,
        CtrlSlt = 3'b100,
        CtrlNot = 3'b101
    } alu_ctrl_e;

    // Logical ops take the immediate zero-extended; everything else sign-extends.
    function automatic logic imm_zero_ext(input logic [2:0] op);
        return (op == CtrlAnd) || (op == CtrlOr);
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file with two combinational read ports (write-through bypass) and one write port.
module reg_file_2r1w
    import operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth,
    parameter int unsigned NREG  = NumRegs
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [RegAddrW-1:0] raddr_a_i,
    output logic [WIDTH-1:0]    rdata_a_o,
    input  logic [RegAddrW-1:0] raddr_b_i,
    output logic [WIDTH-1:0]    rdata_b_o,
    input  logic                we_i,
    input  logic [RegAddrW-1:0] waddr_i,
    input  logic [WIDTH-1:0]    wdata_i
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic             wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0)                 ? '0      :
                       (wr_en && waddr_i == raddr_a_i)   ? wdata_i :
                                                           regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0)                 ? '0      :
                       (wr_en && waddr_i == raddr_b_i)   ? wdata_i :
                                                           regs_q[raddr_b_i];

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: reads the register file, forms the b operand and holds one ALU
// operation in a valid/ready output register.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth,
    parameter int unsigned NREG  = NumRegs
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RegAddrW-1:0] rs,
    input  logic [RegAddrW-1:0] rt,
    input  logic [ImmWidth-1:0] imm,
    input  logic                use_imm,
    input  logic [2:0]          op,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [RegAddrW-1:0] wb_addr,
    input  logic [WIDTH-1:0]    wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    a,
    output logic [WIDTH-1:0]    b,
    output logic [2:0]          ctrl
);

    logic [WIDTH-1:0] rs_val, rt_val, imm_ext, b_sel;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic             accept;

    reg_file_2r1w #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_reg_file (
        .clk_i     (clk),
        .rst_i     (rst),
        .raddr_a_i (rs),
        .rdata_a_o (rs_val),
        .raddr_b_i (rt),
        .rdata_b_o (rt_val),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign imm_ext = imm_zero_ext(op) ? {{(WIDTH - ImmWidth){1'b0}}, imm}
                                      : {{(WIDTH - ImmWidth){imm[ImmWidth-1]}}, imm};
    assign b_sel   = use_imm ? imm_ext : rt_val;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        // accept already implies !flush, so flush only needs to drop the held op.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            a_d     = rs_val;
            b_d     = b_sel;
            ctrl_d  = op;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign ctrl      = ctrl_q;
    assign out_valid = valid_q;

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath width; NREG, 32, register count (address width 5).
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 Port clk SHALL be input, 1 bit: rising-edge clock.
REQ-004 Port rst SHALL be input, 1 bit: asynchronous active-high reset.
REQ-005 Port in_valid SHALL be input, 1 bit: decoded instruction fields present.
REQ-006 Port in_ready SHALL be output, 1 bit: stage accepts fields this cycle.
REQ-007 Port rs SHALL be input, 5 bits: source register for operand a.
REQ-008 Port rt SHALL be input, 5 bits: source register for operand b.
REQ-009 Port imm SHALL be input, 16 bits: immediate field.
REQ-010 Port use_imm SHALL be input, 1 bit: b comes from imm instead of rt.
REQ-011 Port op SHALL be input, 3 bits: ALU control code (000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, others NOT a).
REQ-012 Port flush SHALL be input, 1 bit: discard held and incoming operation.
REQ-013 Port wb_en SHALL be input, 1 bit: register write strobe.
REQ-014 Port wb_addr SHALL be input, 5 bits: write address.
REQ-015 Port wb_data SHALL be input, WIDTH bits: write data.
REQ-016 Port out_valid SHALL be output, 1 bit: a/b/ctrl hold a valid operation.
REQ-017 Port out_ready SHALL be input, 1 bit: ALU side consumes this cycle.
REQ-018 Ports a, b SHALL be outputs, WIDTH bits each, and ctrl output, 3 bits: registered ALU operands and control.

Function
REQ-019 Register 0 SHALL always read 0; writes to address 0 are ignored.
REQ-020 Writes SHALL occur on the rising clk edge when wb_en=1 and wb_addr!=0.
REQ-021 Read bypass: when wb_en=1 and wb_addr equals a nonzero rs/rt in the same cycle, the read SHALL return wb_data.
REQ-022 in_ready SHALL equal !flush && (!out_valid || out_ready), combinationally.
REQ-023 Accept = in_valid && in_ready; on accept, a, b, ctrl SHALL be loaded next edge and out_valid set to 1 (latency 1 cycle).
REQ-024 b SHALL be: rt value if use_imm=0; zero-extended imm if use_imm=1 and op is 000 or 001; sign-extended imm otherwise.
REQ-025 ctrl SHALL be op passed unchanged; codes 101-111 are forwarded, not remapped.
REQ-026 If out_valid && out_ready and no accept, out_valid SHALL clear next edge; a/b/ctrl hold.
REQ-027 Simultaneous consume and accept SHALL replace the held operation with no bubble (out_valid stays 1).
REQ-028 If out_valid=1 and out_ready=0, a/b/ctrl SHALL remain stable until consumed or flushed.
REQ-029 flush=1 SHALL clear out_valid next edge, block acceptance, and leave register-file writes unaffected.

Reset
REQ-030 While rst=1, all NREG-1 registers, a, b, ctrl and out_valid SHALL be 0, independent of clk.
REQ-031 A write coinciding with rst SHALL be lost; after rst deasserts, the first edge behaves normally.

Structure
REQ-032 A shared package SHALL hold WIDTH, register address width, and the ALU control code constants (AND, OR, ADD, SUB, SLT, NOT).
REQ-033 The register file SHALL be a sub-module reg_file_2r1w (two combinational reads with bypass, one synchronous write, async reset).

Verification
REQ-034 Write r5=0x0000_1234, then rs=5, rt=0, use_imm=0, op=010 -> next cycle a=0x1234, b=0, ctrl=010, out_valid=1.
REQ-035 wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF while rs=7 accepted -> a=0xDEADBEEF (bypass); wb_addr=0 write -> r0 reads 0.
REQ-036 imm=0xFFFF, use_imm=1, op=010 -> b=0xFFFF_FFFF; same with op=001 -> b=0x0000_FFFF.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 with in_valid=1 -> new operation next cycle, out_valid stays 1.
REQ-038 flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming op dropped, concurrent wb write still lands.
REQ-039 rst pulsed mid-stream between edges -> out_valid, a, b, ctrl=0 immediately; previously written r5 reads 0.
